// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : stall/bubble scheduler for the 5-stage in-order RV64 pipeline
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic             valid_e,
  input  logic [4:0]       dst_e,
  input  logic             load_e,
  input  logic             md_e,
  input  logic             redirect_e,
  input  logic             i_wait,
  input  logic             d_wait,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             bubble_d,
  output logic             bubble_e,
  output logic             bubble_m,
  output logic             bubble_w,
  output logic             md_busy
);

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam bit             MD_MULTI = (MD_LAT > 1);
  localparam logic [CNT_W-1:0] MD_INIT = MD_MULTI ? CNT_W'(MD_LAT - 2) : '0;

  md_state_t        md_st, md_st_nxt;
  logic [CNT_W-1:0] md_cnt, md_cnt_nxt;
  logic             redir_pend, redir_pend_nxt;

  logic md_start;
  logic md_hold;
  logic md_busy_int;
  logic load_use;
  logic redir_take;

  always_comb begin
    md_start    = valid_e & md_e & MD_MULTI & ~d_wait;
    // At count zero E is still held while d_wait keeps the whole back end frozen
    md_hold     = (md_cnt != '0) | d_wait;
    md_busy_int = (md_st == MD_IDLE) ? md_start : md_hold;

    load_use = valid_d & valid_e & load_e & (dst_e != 5'd0) &
               ((rs1_used_d & (rs1_d == dst_e)) | (rs2_used_d & (rs2_d == dst_e)));

    redir_take = redirect_e & ~d_wait & ~md_busy_int;
  end

  always_comb begin
    md_st_nxt  = md_st;
    md_cnt_nxt = md_cnt;
    case (md_st)
      MD_IDLE: begin
        if (md_start) begin
          md_st_nxt  = MD_BUSY;
          md_cnt_nxt = MD_INIT;
        end
      end
      MD_BUSY: begin
        if (md_cnt != '0) begin
          md_cnt_nxt = md_cnt - CNT_W'(1);
        end else if (!d_wait) begin
          md_st_nxt = MD_IDLE;
        end
      end
      default: begin
        md_st_nxt  = MD_IDLE;
        md_cnt_nxt = '0;
      end
    endcase

    redir_pend_nxt = redir_pend;
    if (redir_take && i_wait) begin
      redir_pend_nxt = 1'b1;
    end else if (!i_wait) begin
      redir_pend_nxt = 1'b0;
    end
  end

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    bubble_d = 1'b0;
    bubble_e = 1'b0;
    bubble_m = 1'b0;
    bubble_w = 1'b0;
    md_busy  = 1'b0;

    if (reset) begin
      bubble_d = 1'b1;
      bubble_e = 1'b1;
      bubble_m = 1'b1;
      bubble_w = 1'b1;
    end else begin
      md_busy = md_busy_int;
      if (d_wait) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        stall_m  = 1'b1;
        bubble_w = 1'b1;
      end else if (md_busy_int) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        bubble_m = 1'b1;
      end else begin
        if (redirect_e) begin
          bubble_d = 1'b1;
          bubble_e = 1'b1;
        end else if (load_use) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          bubble_e = 1'b1;
        end else if (i_wait) begin
          stall_f  = 1'b1;
          bubble_d = 1'b1;
        end
        // Drop the wrong-path fetch that lands once the old request completes
        if (redir_pend && !i_wait && !stall_d) begin
          bubble_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_st      <= MD_IDLE;
      md_cnt     <= '0;
      redir_pend <= 1'b0;
    end else begin
      md_st      <= md_st_nxt;
      md_cnt     <= md_cnt_nxt;
      redir_pend <= redir_pend_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int MD_LAT = 4;
  localparam int CNT_W  = 3;

  // Output vector order: {stall_f,stall_d,stall_e,stall_m,bubble_d,bubble_e,bubble_m,bubble_w,md_busy}
  localparam logic [8:0] O_NONE  = 9'b0000_0000_0;
  localparam logic [8:0] O_RST   = 9'b0000_1111_0;
  localparam logic [8:0] O_DWAIT = 9'b1111_0001_0;
  localparam logic [8:0] O_DWMD  = 9'b1111_0001_1;
  localparam logic [8:0] O_MD    = 9'b1110_0010_1;
  localparam logic [8:0] O_REDIR = 9'b0000_1100_0;
  localparam logic [8:0] O_LU    = 9'b1100_0100_0;
  localparam logic [8:0] O_IWAIT = 9'b1000_1000_0;
  localparam logic [8:0] O_DROP  = 9'b0000_1000_0;

  logic clk = 1'b0;
  logic reset;
  logic valid_d, rs1_used_d, rs2_used_d, valid_e, load_e, md_e, redirect_e, i_wait, d_wait;
  logic [4:0] rs1_d, rs2_d, dst_e;
  logic stall_f, stall_d, stall_e, stall_m;
  logic bubble_d, bubble_e, bubble_m, bubble_w, md_busy;
  logic [8:0] obs;

  int errors = 0;
  int checks = 0;

  assign obs = {stall_f, stall_d, stall_e, stall_m, bubble_d, bubble_e, bubble_m, bubble_w, md_busy};

  always #5 clk = ~clk;

  pipe_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .valid_e(valid_e), .dst_e(dst_e), .load_e(load_e), .md_e(md_e),
    .redirect_e(redirect_e), .i_wait(i_wait), .d_wait(d_wait),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .bubble_d(bubble_d), .bubble_e(bubble_e), .bubble_m(bubble_m), .bubble_w(bubble_w),
    .md_busy(md_busy)
  );

  task automatic clear_in();
    valid_d = 0; rs1_d = 0; rs2_d = 0; rs1_used_d = 0; rs2_used_d = 0;
    valid_e = 0; dst_e = 0; load_e = 0; md_e = 0;
    redirect_e = 0; i_wait = 0; d_wait = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    valid_e = 1; load_e = 1; dst_e = 5'd5;
    valid_d = 1; rs2_d = 5'd5; rs2_used_d = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_in();
    #2;
    checks++;
    if (obs !== O_RST) $display("FAIL reset_hold obs=%b exp=%b", obs, O_RST);
    if (obs !== O_RST) errors++;
    next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== O_NONE) begin
      errors++;
      $display("FAIL reset_release obs=%b exp=%b", obs, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [8:0] exp [7] = '{O_LU, O_NONE, O_NONE, O_LU, O_NONE, O_NONE, O_NONE};
    for (int i = 0; i < 7; i++) begin
      clear_in();
      case (i)
        0: set_load_use();
        1: ;
        2: begin set_load_use(); dst_e = 5'd0; rs2_d = 5'd0; end
        3: begin set_load_use(); rs2_used_d = 0; dst_e = 5'd9; rs1_d = 5'd9; rs1_used_d = 1; end
        4: begin set_load_use(); rs2_used_d = 0; dst_e = 5'd9; rs1_d = 5'd9; end
        5: begin set_load_use(); load_e = 0; end
        default: begin set_load_use(); dst_e = 5'd21; rs2_d = 5'd5; end
      endcase
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL load_use[%0d] obs=%b exp=%b", i, obs, exp[i]);
      end
      next_cycle();
    end
    clear_in();
  endtask

  task automatic test_md();
    logic [8:0] exp [8] = '{O_MD, O_MD, O_MD, O_NONE, O_MD, O_MD, O_MD, O_NONE};
    clear_in();
    valid_e = 1; md_e = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL md_occupy[%0d] obs=%b exp=%b", i, obs, exp[i]);
      end
      next_cycle();
    end
    clear_in();
    #1;
    checks++;
    if (obs !== O_NONE) begin
      errors++;
      $display("FAIL md_drain obs=%b exp=%b", obs, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_md_dwait();
    logic [8:0] exp [11] = '{O_MD, O_DWMD, O_DWMD, O_DWMD, O_DWMD, O_DWMD,
                             O_NONE, O_MD, O_MD, O_MD, O_NONE};
    clear_in();
    valid_e = 1; md_e = 1;
    for (int i = 0; i < 11; i++) begin
      d_wait = (i >= 1 && i <= 5);
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL md_dwait[%0d] obs=%b exp=%b", i, obs, exp[i]);
      end
      next_cycle();
    end
    clear_in();
    next_cycle();
  endtask

  task automatic test_redirect();
    logic       rd [9] = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
    logic       iw [9] = '{1, 1, 1, 0, 0, 1, 1, 0, 0};
    logic [8:0] exp [9] = '{O_REDIR, O_IWAIT, O_IWAIT, O_DROP, O_NONE,
                            O_REDIR, O_REDIR, O_DROP, O_NONE};
    for (int i = 0; i < 9; i++) begin
      clear_in();
      redirect_e = rd[i];
      i_wait     = iw[i];
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL redirect[%0d] obs=%b exp=%b", i, obs, exp[i]);
      end
      next_cycle();
    end
    clear_in();
  endtask

  task automatic test_priority();
    logic [8:0] exp [4] = '{O_IWAIT, O_REDIR, O_NONE, O_LU};
    for (int i = 0; i < 4; i++) begin
      clear_in();
      case (i)
        0: i_wait = 1;
        1: begin set_load_use(); redirect_e = 1; end
        2: ;
        default: begin set_load_use(); i_wait = 1; end
      endcase
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL priority[%0d] obs=%b exp=%b", i, obs, exp[i]);
      end
      next_cycle();
    end
    clear_in();
  endtask

  task automatic test_simultaneous();
    logic [8:0] exp [6] = '{O_DWAIT, O_NONE, O_REDIR, O_DWAIT, O_DROP, O_NONE};
    for (int i = 0; i < 6; i++) begin
      clear_in();
      case (i)
        0, 3: begin set_load_use(); redirect_e = 1; d_wait = 1; i_wait = 1; end
        2: begin redirect_e = 1; i_wait = 1; end
        default: ;
      endcase
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL simultaneous[%0d] obs=%b exp=%b", i, obs, exp[i]);
      end
      next_cycle();
    end
    clear_in();
  endtask

  task automatic test_reset_busy();
    clear_in();
    valid_e = 1; md_e = 1;
    next_cycle();
    checks++;
    if (obs !== O_MD) begin
      errors++;
      $display("FAIL rst_busy_pre obs=%b exp=%b", obs, O_MD);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== O_RST) begin
      errors++;
      $display("FAIL rst_busy_async obs=%b exp=%b", obs, O_RST);
    end
    clear_in();
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== O_NONE) begin
      errors++;
      $display("FAIL rst_busy_release obs=%b exp=%b", obs, O_NONE);
    end
    next_cycle();
    valid_e = 1; md_e = 1;
    #1;
    checks++;
    if (obs !== O_MD) begin
      errors++;
      $display("FAIL rst_busy_idle_restart obs=%b exp=%b", obs, O_MD);
    end
    for (int i = 0; i < 3; i++) next_cycle();
    #1;
    checks++;
    if (obs !== O_NONE) begin
      errors++;
      $display("FAIL rst_busy_full_lat obs=%b exp=%b", obs, O_NONE);
    end
    clear_in();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_md();
    test_md_dwait();
    test_redirect();
    test_priority();
    test_simultaneous();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
